uart_word_receiver: RTL and testbench

//  Serial front end of the program-load path: deserialises 8N1 UART bytes from the host.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_byte.sv | 109 ++++++++++
 rtl/uart_word_receiver.sv | 126 ++++++++++++
 tb/tb_uart_word_receiver.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and defaults for the UART receive path.
//   rx_state_t                 - byte receiver FSM states
//   UART_DEFAULT_CLKS_PER_BIT  - default baud divider (clock cycles per bit)
//   UART_DEFAULT_FIFO_DEPTH    - default word FIFO depth
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 2604;
  localparam int unsigned UART_DEFAULT_FIFO_DEPTH   = 4;

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART byte receiver with a 2-FF input synchroniser.
// Ports:
//   clk        in   system clock, posedge
//   rst        in   asynchronous active-high reset
//   rx         in   raw serial line, idle high, asynchronous to clk
//   byte_data  out  last received byte (valid while byte_valid is high)
//   byte_valid out  one-cycle strobe: byte with good stop bit received
//   frame_err  out  one-cycle strobe: stop bit sampled low, byte discarded
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic            rx_m;
  logic            rx_s;
  rx_state_t       state;
  rx_state_t       state_n;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_n;
  logic [2:0]      bit_idx;
  logic [2:0]      bit_idx_n;
  logic [7:0]      shreg;
  logic [7:0]      shreg_n;
  logic            done_n;
  logic            ferr_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_idx_n;
      shreg      <= shreg_n;
      byte_valid <= done_n;
      frame_err  <= ferr_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 1'b1;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    done_n    = 1'b0;
    ferr_n    = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (cnt == HALF) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          // Line back high at mid start bit: treat as a glitch, no error.
          state_n   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_n     = '0;
          shreg_n   = {rx_s, shreg[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
          if (rx_s) done_n = 1'b1;
          else      ferr_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign byte_data = shreg;

endmodule

// File: rtl/uart_word_receiver.sv
// uart_word_receiver: UART program-load front end. Packs received bytes
// big-endian into 32-bit words and buffers them in a first-word
// fall-through FIFO with a valid/ready output.
// Ports:
//   CLK          in   clock, posedge
//   RESET        in   asynchronous active-high reset
//   UART_RX      in   raw serial line, idle high
//   CLEAR        in   sync pulse: drop partial word, empty FIFO, clear OVERFLOW
//   WORD_DATA    out  FIFO head word, first received byte in [31:24]
//   WORD_VALID   out  FIFO non-empty
//   WORD_READY   in   pop head when WORD_VALID & WORD_READY
//   FRAME_ERROR  out  one-cycle pulse on a bad stop bit
//   OVERFLOW     out  sticky: a completed word was dropped (FIFO full)
module uart_word_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = UART_DEFAULT_FIFO_DEPTH
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        UART_RX,
  input  logic        CLEAR,
  output logic [31:0] WORD_DATA,
  output logic        WORD_VALID,
  input  logic        WORD_READY,
  output logic        FRAME_ERROR,
  output logic        OVERFLOW
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_ferr;

  logic        byte_stb;
  logic [7:0]  byte_q;
  logic [1:0]  idx;
  logic [23:0] word_hi;
  logic        push;
  logic [31:0] push_word;

  logic [31:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        pop;
  logic        wr_en;
  logic        ovf;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk        (CLK),
    .rst        (RESET),
    .rx         (UART_RX),
    .byte_data  (rx_byte),
    .byte_valid (rx_valid),
    .frame_err  (rx_ferr)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      byte_stb <= 1'b0;
      byte_q   <= '0;
    end else begin
      byte_stb <= rx_valid;
      if (rx_valid) byte_q <= rx_byte;
    end
  end

  // The last byte of a word goes straight from byte_q into the FIFO, so
  // only the upper three lanes need holding registers.
  assign push      = byte_stb && (idx == 2'd3) && !CLEAR;
  assign push_word = {word_hi, byte_q};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      idx     <= '0;
      word_hi <= '0;
    end else if (CLEAR || rx_ferr) begin
      idx <= '0;
    end else if (byte_stb) begin
      case (idx)
        2'd0:    word_hi[23:16] <= byte_q;
        2'd1:    word_hi[15:8]  <= byte_q;
        2'd2:    word_hi[7:0]   <= byte_q;
        default: ;
      endcase
      idx <= idx + 2'd1;
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && WORD_READY;
  assign wr_en = push && (!full || pop);

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_word;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else if (CLEAR) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (push && full && !pop) ovf <= 1'b1;
    end
  end

  assign WORD_VALID  = !empty;
  assign WORD_DATA   = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign FRAME_ERROR = rx_ferr;
  assign OVERFLOW    = ovf;

endmodule

// File: tb/tb_uart_word_receiver.sv
// Testbench for uart_word_receiver (CLKS_PER_BIT=16, FIFO_DEPTH=4).
module tb_uart_word_receiver;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  // Edge (counted from the edge before the start bit is driven) on which
  // the stop bit is sampled: 2 sync stages + idle detect, half a bit, 9 bits.
  localparam int S_EDGE = 3 + CPB / 2 + 9 * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic        clear = 1'b0;
  logic        ready_main = 1'b0;
  logic        ready_rand = 1'b0;
  logic        rand_mode = 1'b0;
  logic        ready;
  logic [31:0] word_data;
  logic        word_valid;
  logic        frame_error;
  logic        overflow;

  assign ready = rand_mode ? ready_rand : ready_main;

  uart_word_receiver #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .CLK         (clk),
    .RESET       (rst),
    .UART_RX     (rx),
    .CLEAR       (clear),
    .WORD_DATA   (word_data),
    .WORD_VALID  (word_valid),
    .WORD_READY  (ready),
    .FRAME_ERROR (frame_error),
    .OVERFLOW    (overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: expected FIFO contents, partial word, sticky overflow.
  logic [31:0] mq[$];
  int          m_idx = 0;
  logic [31:0] m_part = '0;
  logic        m_ovf = 1'b0;
  int          fe_exp = 0;
  int          fe_seen = 0;
  int          words_got = 0;

  logic [31:0] exp_w;
  logic        hold_prev = 1'b0;
  logic [31:0] held = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%h required=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mq.delete();
    m_idx  = 0;
    m_part = '0;
    m_ovf  = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok) begin
      m_idx = 0;
      fe_exp++;
    end else begin
      m_part = {m_part[23:0], b};
      if (m_idx == 3) begin
        if (mq.size() < DEPTH) mq.push_back(m_part);
        else m_ovf = 1'b1;
        m_idx = 0;
      end else begin
        m_idx++;
      end
    end
  endtask

  // Called just after a posedge; returns just after a posedge one frame later.
  task automatic send_byte(input logic [7:0] b, input bit stop_ok,
                           input bit chk_lat, input bit pulse_rdy);
    rx = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cyc(CPB);
    end
    rx = stop_ok;
    cyc(S_EDGE + 1 - 9 * CPB);
    if (chk_lat) check("lat_before", {31'd0, word_valid}, 32'd0);
    if (pulse_rdy) ready_main = 1'b1;
    cyc(1);
    model_byte(b, stop_ok);
    if (pulse_rdy) ready_main = 1'b0;
    if (chk_lat) begin
      check("lat_valid", {31'd0, word_valid}, 32'd1);
      check("lat_data", word_data, m_part);
    end
    cyc(1);
    if (chk_lat) check("lat_after", {31'd0, word_valid}, 32'd0);
    cyc(10 * CPB - S_EDGE - 3);
    rx = 1'b1;
    if (!stop_ok) cyc(2 * CPB);
  endtask

  task automatic send_word(input logic [31:0] w, input bit chk_lat, input bit pulse_rdy);
    for (int k = 0; k < 4; k++)
      send_byte(w[31 - 8 * k -: 8], 1'b1, chk_lat && (k == 3), pulse_rdy && (k == 3));
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 200;
    ready_main = 1'b1;
    while ((mq.size() != 0 || word_valid) && budget > 0) begin
      cyc(1);
      budget--;
    end
    check({tag, "_model_empty"}, mq.size(), 0);
    check({tag, "_valid_low"}, {31'd0, word_valid}, 32'd0);
  endtask

  // Monitor: every pop must match the model head; data stable while stalled.
  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (frame_error) fe_seen++;
      if (hold_prev && word_valid) begin
        checks++;
        assert (word_data === held) else begin
          errors++;
          $error("FAIL hold_stable got=%h required=%h", word_data, held);
        end
      end
      if (word_valid && ready) begin
        checks++;
        assert (mq.size() != 0) else begin
          errors++;
          $error("FAIL pop_unexpected got=%h required=none", word_data);
        end
        if (mq.size() != 0) begin
          exp_w = mq.pop_front();
          checks++;
          assert (word_data === exp_w) else begin
            errors++;
            $error("FAIL pop_data got=%h required=%h", word_data, exp_w);
          end
        end
        words_got++;
      end
      hold_prev = word_valid && !ready;
      held      = word_data;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0;
    int f0;
    logic [7:0]  rb;
    logic [31:0] rw;
    bit ok;

    // Reset state
    cyc(3);
    check("rst_valid", {31'd0, word_valid}, 32'd0);
    check("rst_data", word_data, 32'd0);
    check("rst_ferr", {31'd0, frame_error}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    cyc(4);

    // 1: single word, exact latency, one-cycle VALID with READY=1
    ready_main = 1'b1;
    w0 = words_got;
    send_word(32'hDEADBEEF, 1'b1, 1'b0);
    cyc(4);
    check("t1_words", words_got - w0, 1);

    // 2: READY=0, six random words; last two dropped, overflow sticky
    ready_main = 1'b0;
    w0 = words_got;
    for (int i = 0; i < 6; i++) begin
      send_word($urandom, 1'b0, 1'b0);
      if (i == 3) check("t2_ovf_w4", {31'd0, overflow}, {31'd0, m_ovf});
      if (i == 4) check("t2_ovf_w5", {31'd0, overflow}, {31'd0, m_ovf});
    end
    check("t2_model_ovf", {31'd0, overflow}, 32'd1);
    drain("t2");
    check("t2_words", words_got - w0, 4);
    check("t2_ovf_sticky", {31'd0, overflow}, 32'd1);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    model_reset();
    check("clr_ovf", {31'd0, overflow}, 32'd0);

    // 3: frame error discards the partial word
    w0 = words_got;
    f0 = fe_seen;
    send_byte(8'h12, 1'b1, 1'b0, 1'b0);
    send_byte(8'h34, 1'b1, 1'b0, 1'b0);
    send_byte(8'h56, 1'b0, 1'b0, 1'b0);
    send_word(32'h11223344, 1'b0, 1'b0);
    cyc(4);
    check("t3_fe_pulses", fe_seen - f0, 1);
    check("t3_fe_model", fe_seen, fe_exp);
    check("t3_words", words_got - w0, 1);

    // 4: 5-cycle low glitch produces nothing and leaves alignment intact
    w0 = words_got;
    f0 = fe_seen;
    rx = 1'b0;
    cyc(5);
    rx = 1'b1;
    cyc(3 * CPB);
    check("t4_fe", fe_seen - f0, 0);
    check("t4_no_word", {31'd0, word_valid}, 32'd0);
    send_word(32'h0BADF00D, 1'b0, 1'b0);
    cyc(4);
    check("t4_words", words_got - w0, 1);

    // CLEAR drops a partial word
    w0 = words_got;
    send_byte(8'hAA, 1'b1, 1'b0, 1'b0);
    send_byte(8'hBB, 1'b1, 1'b0, 1'b0);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    model_reset();
    send_word(32'h01020304, 1'b0, 1'b0);
    cyc(4);
    check("clr_words", words_got - w0, 1);

    // 5: FIFO full, READY pulsed exactly on the push edge of word 5
    ready_main = 1'b0;
    w0 = words_got;
    for (int i = 0; i < 4; i++) send_word($urandom, 1'b0, 1'b0);
    send_word($urandom, 1'b0, 1'b1);
    check("t5_ovf", {31'd0, overflow}, 32'd0);
    drain("t5");
    check("t5_words", words_got - w0, 5);

    // 6: reset mid byte 2 with a word waiting in the FIFO
    ready_main = 1'b0;
    send_word($urandom, 1'b0, 1'b0);
    check("t6_pre_valid", {31'd0, word_valid}, 32'd1);
    send_byte(8'hA5, 1'b1, 1'b0, 1'b0);
    rx = 1'b0;
    cyc(CPB);
    rx = 1'b1;
    cyc(3 * CPB);
    rst = 1'b1;
    cyc(1);
    model_reset();
    check("t6_rst_valid", {31'd0, word_valid}, 32'd0);
    check("t6_rst_data", word_data, 32'd0);
    check("t6_rst_ferr", {31'd0, frame_error}, 32'd0);
    check("t6_rst_ovf", {31'd0, overflow}, 32'd0);
    cyc(2);
    rst = 1'b0;
    cyc(6 * CPB);
    ready_main = 1'b1;
    w0 = words_got;
    f0 = fe_seen;
    send_word(32'hCAFEF00D, 1'b0, 1'b0);
    drain("t6");
    check("t6_words", words_got - w0, 1);
    check("t6_fe_tol", {31'd0, (fe_seen - f0) <= 1}, 32'd1);
    fe_exp = fe_exp + (fe_seen - f0);

    // 7: random bytes with occasional bad stop bits, random READY
    rand_mode = 1'b1;
    f0 = fe_seen;
    for (int i = 0; i < 24; i++) begin
      rb = 8'($urandom);
      ok = ($urandom_range(0, 7) != 0);
      send_byte(rb, ok, 1'b0, 1'b0);
    end
    rand_mode = 1'b0;
    drain("t7");
    check("t7_fe", fe_seen, fe_exp);
    check("t7_ovf", {31'd0, overflow}, {31'd0, m_ovf});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  always @(posedge clk) begin
    #1;
    ready_rand = 1'($urandom_range(0, 1));
  end

endmodule
